imem_loader: RTL and testbench

//  Writer side of the CPU instruction memory. Receives a program as a byte

---
 rtl/imem_loader.sv | 103 ++++++++++
 tb/tb_imem_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream IMEM loader: HDR N, N x {hi,lo} words, CSUM; holds the CPU in reset until a load passes its checksum.
// Latency: the IMEM write pulse comes the cycle after the lo byte is taken; the next byte is taken one cycle later.
// Backpressure: in_ready drops during WRITE/DONE/ERR, and the source holds its byte until in_ready returns.
module imem_loader #(
    parameter int IM_SIZE     = 8,
    parameter int OPCODE_SIZE = 4,
    parameter int RF_SIZE     = 4,
    localparam int WORD_W     = OPCODE_SIZE + 3 * RF_SIZE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               reload,
    output logic               mem_we,
    output logic [IM_SIZE-1:0] mem_addr,
    output logic [WORD_W-1:0]  mem_din,
    output logic               cpu_rst,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_HDR, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t             state, state_nxt;
    logic [IM_SIZE-1:0] addr, last_addr;
    logic [7:0]         hi_byte, lo_byte, sum;
    logic               accept;

    assign accept   = in_valid && in_ready;
    assign mem_addr = addr;
    assign mem_din  = {hi_byte, lo_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HDR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR:   if (in_valid) state_nxt = S_HI;
            S_HI:    if (in_valid) state_nxt = S_LO;
            S_LO:    if (in_valid) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (addr == last_addr) ? S_CSUM : S_HI;
            S_CSUM:  if (in_valid) state_nxt = (8'(sum + in_data) == 8'h00) ? S_DONE : S_ERR;
            S_DONE:  if (reload) state_nxt = S_HDR;
            S_ERR:   if (reload) state_nxt = S_HDR;
            default: state_nxt = S_HDR;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_HDR, S_HI, S_LO, S_CSUM: in_ready = 1'b1;
            S_WRITE:                   mem_we   = 1'b1;
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            S_ERR:                     err      = 1'b1;
            default: ;
        endcase
    end

    // A header of 0 wraps to an all-ones terminal address, giving a full 2^IM_SIZE-word load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            last_addr <= '0;
            hi_byte   <= '0;
            lo_byte   <= '0;
            sum       <= '0;
        end else begin
            case (state)
                S_HDR: if (accept) begin
                    last_addr <= IM_SIZE'(in_data) - IM_SIZE'(1);
                    sum       <= in_data;
                    addr      <= '0;
                end
                S_HI: if (accept) begin
                    hi_byte <= in_data;
                    sum     <= sum + in_data;
                end
                S_LO: if (accept) begin
                    lo_byte <= in_data;
                    sum     <= sum + in_data;
                end
                S_WRITE: if (addr != last_addr) addr <= addr + IM_SIZE'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams hand-built programs and checks writes, status and reset handling.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        reload;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Write monitor: logs every IMEM write and flags addresses out of sequence within a load.
    logic [23:0] wr_log [0:511];
    int wr_total  = 0;
    int seq_err   = 0;
    int load_base = 0;
    int seq_base  = 0;

    imem_loader #(.IM_SIZE(8), .OPCODE_SIZE(4), .RF_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (mem_addr !== 8'(wr_total - load_base)) seq_err++;
            if (wr_total < 512) wr_log[wr_total] = {mem_addr, mem_din};
            wr_total++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("send_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic start_load();
        load_base = wr_total;
        seq_base  = seq_err;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_err", 32'(err), 32'd0);
        chk("reload_rdy", 32'(in_ready), 32'd1);
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_err"}, 32'(err), 32'(e));
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!d));
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_din"}, 32'(mem_din), 32'd0);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] h;
        logic [7:0] l;
        int bad;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: good two-word load, with write-cycle timing
        start_load();
        send(8'h02); send(8'h12); send(8'h34);
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_wr_rdy", 32'(in_ready), 32'd0);
        chk("t1_addr0", 32'(mem_addr), 32'h00);
        chk("t1_din0", 32'(mem_din), 32'h1234);
        send(8'h56); send(8'h78);
        @(negedge clk);
        chk("t1_csum_cpu_rst", 32'(cpu_rst), 32'd1);
        send(8'hEA);
        chk_status("t1", 1'b1, 1'b0);
        chk("t1_wcnt", 32'(wr_total - load_base), 32'd2);
        chk("t1_w0", 32'(wr_log[load_base]), 32'h001234);
        chk("t1_w1", 32'(wr_log[load_base + 1]), 32'h015678);

        // 2: bad checksum
        pulse_reload();
        start_load();
        send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h00);
        chk_status("t2", 1'b0, 1'b1);
        chk("t2_wcnt", 32'(wr_total - load_base), 32'd2);
        chk("t2_w1", 32'(wr_log[load_base + 1]), 32'h015678);

        // 3: in_valid held through WRITE
        pulse_reload();
        start_load();
        send(8'h02); send(8'h12); send(8'h34);
        in_data  = 8'h56;
        in_valid = 1'b1;
        chk("t3_wr_rdy", 32'(in_ready), 32'd0);
        chk("t3_wr_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        chk("t3_hi_rdy", 32'(in_ready), 32'd1);
        chk("t3_hi_we", 32'(mem_we), 32'd0);
        chk("t3_hi_addr", 32'(mem_addr), 32'h01);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        send(8'h78); send(8'hEA);
        chk_status("t3", 1'b1, 1'b0);
        chk("t3_wcnt", 32'(wr_total - load_base), 32'd2);
        chk("t3_w0", 32'(wr_log[load_base]), 32'h001234);
        chk("t3_w1", 32'(wr_log[load_base + 1]), 32'h015678);

        // 4: HDR=0 loads all 256 words; word i = {i, i^5A}
        pulse_reload();
        start_load();
        s = 8'h00;
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            h = 8'(i);
            l = h ^ 8'h5A;
            send(h); send(l);
            s = s + h + l;
        end
        send(8'h00 - s);
        chk_status("t4", 1'b1, 1'b0);
        chk("t4_wcnt", 32'(wr_total - load_base), 32'd256);
        chk("t4_seq", 32'(seq_err - seq_base), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            h = 8'(i);
            if (wr_log[load_base + i] !== {h, h, h ^ 8'h5A}) bad++;
        end
        chk("t4_contents", 32'(bad), 32'd0);
        chk("t4_first", 32'(wr_log[load_base]), 32'h00005A);
        chk("t4_last", 32'(wr_log[load_base + 255]), 32'hFFFFA5);

        // 5: async reset after the third word of a five-word load
        pulse_reload();
        start_load();
        send(8'h05);
        send(8'h11); send(8'h11); send(8'h22); send(8'h22); send(8'h33); send(8'h33);
        @(negedge clk);
        chk("t5_wcnt", 32'(wr_total - load_base), 32'd3);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_load();
        send(8'h01); send(8'h11); send(8'h22); send(8'hCC);
        chk_status("t5", 1'b1, 1'b0);
        chk("t5_wcnt2", 32'(wr_total - load_base), 32'd1);
        chk("t5_w0", 32'(wr_log[load_base]), 32'h001122);

        // 6: reload from DONE, overwrite address 0
        pulse_reload();
        start_load();
        send(8'h01); send(8'hAB); send(8'hCD); send(8'h87);
        chk_status("t6", 1'b1, 1'b0);
        chk("t6_wcnt", 32'(wr_total - load_base), 32'd1);
        chk("t6_w0", 32'(wr_log[load_base]), 32'h00ABCD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
